// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the gameboy CPU core: 16-bit register
// targets, interrupt dispatch sequencer states and interrupt vector helpers.
package gb_cpu_common_pkg;

  localparam int          NUM_INT       = 5;
  localparam int          INT_IDX_W     = 3;
  localparam logic [15:0] VECTOR_BASE   = 16'h0040;
  localparam int          VECTOR_STRIDE = 8;

  // 16-bit register pair targets on the IDU write port
  typedef enum logic [2:0] {
    REG_BC = 3'd0,
    REG_DE = 3'd1,
    REG_HL = 3'd2,
    REG_SP = 3'd3,
    REG_PC = 3'd4
  } regfile_r16_t;

  // Interrupt dispatch sequence: one M-cycle per non-idle state
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    D1   = 3'd1,
    D2   = 3'd2,
    D3   = 3'd3,
    D4   = 3'd4,
    D5   = 3'd5
  } int_dispatch_state_t;

  typedef struct packed {
    logic                 valid;
    logic [INT_IDX_W-1:0] idx;
  } int_vec_t;

  // Lowest set bit of pending wins (bit 0 = highest priority)
  function automatic int_vec_t getIntVector(input logic [NUM_INT-1:0] pending);
    int_vec_t r;
    r = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        r.valid = 1'b1;
        r.idx   = INT_IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gb_cpu_int_prio_enc.sv
// Combinational priority encoder: returns the index of the lowest set
// request bit and whether any bit was set.
module gb_cpu_int_prio_enc
  import gb_cpu_common_pkg::*;
#(
  parameter int W  = gb_cpu_common_pkg::NUM_INT,
  parameter int IW = gb_cpu_common_pkg::INT_IDX_W
) (
  input  logic [W-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan from the top so the lowest set bit is the last one assigned
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/gb_cpu_int_dispatch.sv
// Interrupt dispatch sequencer. At an instruction boundary with IME set and
// an enabled interrupt pending, it owns the IDU write port and data bus for
// five M-cycles: rewind PC, push PC high/low onto the stack, load the vector,
// then acknowledge the interrupt.
//
// Handshake: there is no valid/ready pair here. Writes are single-clock
// strobes: idu_wren, if_clear, ime_clear and done are only high on the
// m_tick clock of their state, so a consumer that samples every clock sees
// each event exactly once. bus_wr is a level held for the whole M-cycle.
module gb_cpu_int_dispatch
  import gb_cpu_common_pkg::*;
#(
  parameter int          NUM_INT       = gb_cpu_common_pkg::NUM_INT,
  parameter logic [15:0] VECTOR_BASE   = gb_cpu_common_pkg::VECTOR_BASE,
  parameter int          VECTOR_STRIDE = gb_cpu_common_pkg::VECTOR_STRIDE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m_tick,
  input  logic                instr_boundary,
  input  logic                ime,
  input  logic                halted,
  input  logic [NUM_INT-1:0]  ie,
  input  logic [NUM_INT-1:0]  if_flags,
  input  logic [15:0]         regs_pc,
  input  logic [15:0]         regs_sp,
  output logic                busy,
  output regfile_r16_t        idu_req,
  output logic [15:0]         idu_data,
  output logic                idu_wren,
  output logic [15:0]         bus_addr,
  output logic [7:0]          bus_wdata,
  output logic                bus_wr,
  output logic [NUM_INT-1:0]  if_clear,
  output logic                ime_clear,
  output logic                wake,
  output logic                done,
  output int_dispatch_state_t dbg_state
);

  localparam int IDX_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

  int_dispatch_state_t state_q;
  logic [NUM_INT-1:0]  lat_mask_q;
  logic [NUM_INT-1:0]  pending;
  logic [IDX_W-1:0]    enc_idx;
  logic                enc_valid;
  logic                dispatch_go;
  logic [15:0]         vec_addr;

  assign pending     = ie & if_flags;
  assign wake        = halted && (|pending);
  assign dispatch_go = instr_boundary && ime && (|pending) && !halted;
  assign dbg_state   = state_q;

  gb_cpu_int_prio_enc #(
    .W  (NUM_INT),
    .IW (IDX_W)
  ) u_prio_enc (
    .req   (pending),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Vector for the highest-priority pending source; 0 when nothing is left
  assign vec_addr = enc_valid ? (VECTOR_BASE + 16'(enc_idx) * 16'(VECTOR_STRIDE)) : 16'h0000;

  // Sequence state advances once per M-cycle; the serviced bit is captured in D4
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      lat_mask_q <= '0;
    end else if (m_tick) begin
      case (state_q)
        IDLE: begin
          if (dispatch_go) begin
            state_q    <= D1;
            lat_mask_q <= '0;
          end
        end
        D1: state_q <= D2;
        D2: state_q <= D3;
        D3: state_q <= D4;
        D4: begin
          state_q    <= D5;
          lat_mask_q <= enc_valid ? (NUM_INT'(1) << enc_idx) : '0;
        end
        D5:      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port requests per state; write strobes only on the closing clock
  always_comb begin
    busy      = 1'b0;
    idu_req   = REG_PC;
    idu_data  = 16'h0000;
    idu_wren  = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    bus_wr    = 1'b0;
    if_clear  = '0;
    ime_clear = 1'b0;
    done      = 1'b0;
    case (state_q)
      D1: begin
        busy     = 1'b1;
        idu_req  = REG_PC;
        idu_data = regs_pc - 16'd1;
        idu_wren = m_tick;
      end
      D2: begin
        busy     = 1'b1;
        idu_req  = REG_SP;
        idu_data = regs_sp - 16'd1;
        idu_wren = m_tick;
      end
      D3: begin
        busy      = 1'b1;
        bus_addr  = regs_sp;
        bus_wdata = regs_pc[15:8];
        bus_wr    = 1'b1;
        if (m_tick) begin
          idu_req  = REG_SP;
          idu_data = regs_sp - 16'd1;
          idu_wren = 1'b1;
        end
      end
      D4: begin
        busy      = 1'b1;
        bus_addr  = regs_sp;
        bus_wdata = regs_pc[7:0];
        bus_wr    = 1'b1;
        if (m_tick) begin
          idu_req  = REG_PC;
          idu_data = vec_addr;
          idu_wren = 1'b1;
        end
      end
      D5: begin
        busy = 1'b1;
        if (m_tick) begin
          if_clear  = lat_mask_q;
          ime_clear = 1'b1;
          done      = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
